// File: rtl/multi_input_conditioner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_input_conditioner_pkg                                          |
// | Default configuration constants shared by the conditioner modules.   |
// | Rev 1.0 - initial multi-channel release                              |
// +----------------------------------------------------------------------+
package multi_input_conditioner_pkg;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_WAIT_TIME   = 3;
  localparam int DEFAULT_CHANNELS    = 4;
endpackage
`default_nettype wire

// File: rtl/input_conditioner_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_conditioner_channel                                            |
// | One pin: synchroniser chain, debounce counter, registered edge pulses.|
// | Rev 1.0 - initial multi-channel release                              |
// +----------------------------------------------------------------------+
module input_conditioner_channel
  import multi_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int WAIT_TIME   = DEFAULT_WAIT_TIME
) (
  input  logic clk,
  input  logic reset,
  input  logic noisysignal,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge
);
  localparam int CNT_W = $clog2(WAIT_TIME + 1);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(WAIT_TIME - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_cond;
  logic                   r_pos;
  logic                   r_neg;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_cond <= 1'b0;
      r_pos  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], noisysignal};
      r_pos  <= 1'b0;
      r_neg  <= 1'b0;
      // Any cycle of agreement restarts the run, so short glitches never land.
      if (w_synced == r_cond) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_cond <= w_synced;
        r_cnt  <= '0;
        r_pos  <= w_synced;
        r_neg  <= ~w_synced;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign conditioned  = r_cond;
  assign positiveedge = r_pos;
  assign negativeedge = r_neg;
endmodule
`default_nettype wire

// File: rtl/multi_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_input_conditioner                                              |
// | CHANNELS independent conditioners; optional sticky edge flags via    |
// | MULTI_INPUT_CONDITIONER_STICKY_EN.                                   |
// | Rev 1.0 - initial multi-channel release                              |
// +----------------------------------------------------------------------+
module multi_input_conditioner
  import multi_input_conditioner_pkg::*;
#(
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int WAIT_TIME   = DEFAULT_WAIT_TIME
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisysignal,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  input  logic [CHANNELS-1:0] clearflags,
  output logic [CHANNELS-1:0] edgeflag
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_conditioner_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .WAIT_TIME  (WAIT_TIME)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .noisysignal (noisysignal[i]),
      .conditioned (conditioned[i]),
      .positiveedge(positiveedge[i]),
      .negativeedge(negativeedge[i])
    );
  end

`ifdef MULTI_INPUT_CONDITIONER_STICKY_EN
  logic [CHANNELS-1:0] r_flag;

  // Set takes priority over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag <= '0;
    end else begin
      r_flag <= (r_flag & ~clearflags) | positiveedge | negativeedge;
    end
  end

  assign edgeflag = r_flag;
`else
  logic w_unused_clearflags;
  assign w_unused_clearflags = ^clearflags;
  assign edgeflag = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_multi_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_input_conditioner                                           |
// | Directed self-checking bench for the 4-channel default configuration.|
// | Rev 1.0 - initial multi-channel release                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_multi_input_conditioner;
  logic       clk;
  logic       reset;
  logic [3:0] noisysignal;
  logic [3:0] conditioned;
  logic [3:0] positiveedge;
  logic [3:0] negativeedge;
  logic [3:0] clearflags;
  logic [3:0] edgeflag;

  int r_errors = 0;
  int r_checks = 0;

  multi_input_conditioner dut (
    .clk         (clk),
    .reset       (reset),
    .noisysignal (noisysignal),
    .conditioned (conditioned),
    .positiveedge(positiveedge),
    .negativeedge(negativeedge),
    .clearflags  (clearflags),
    .edgeflag    (edgeflag)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int pos_count;
    logic [5:0] bounce;
    reset       = 1'b1;
    noisysignal = 4'hF;
    clearflags  = 4'h0;

    // Reset held with all pins high
    tick(3);
    check("rst_cond", 32'(conditioned), 32'h0);
    check("rst_pos",  32'(positiveedge), 32'h0);
    check("rst_neg",  32'(negativeedge), 32'h0);
    check("rst_flag", 32'(edgeflag), 32'h0);
    reset = 1'b0;
    tick(4);
    check("rel_cond_e4", 32'(conditioned), 32'h0);
    tick(1);
    check("rel_cond_e5", 32'(conditioned), 32'hF);
    check("rel_pos_e5",  32'(positiveedge), 32'hF);
    check("rel_neg_e5",  32'(negativeedge), 32'h0);
    tick(1);
    check("rel_pos_e6",  32'(positiveedge), 32'h0);
    check("rel_cond_e6", 32'(conditioned), 32'hF);

    // All low again
    noisysignal = 4'h0;
    tick(5);
    check("fall_neg", 32'(negativeedge), 32'hF);
    check("fall_cond", 32'(conditioned), 32'h0);
    tick(3);

    // Glitch of two cycles on ch0
    noisysignal = 4'h1;
    tick(2);
    noisysignal = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("glitch_ch0", {29'd0, conditioned[0], positiveedge[0], negativeedge[0]}, 32'h0);
    end

    // Latency on ch1
    noisysignal = 4'h2;
    tick(4);
    check("lat_rise_e4", 32'(conditioned), 32'h0);
    tick(1);
    check("lat_rise_e5", 32'(conditioned), 32'h2);
    check("lat_pos_e5",  32'(positiveedge), 32'h2);
    tick(1);
    check("lat_pos_e6",  32'(positiveedge), 32'h0);
    tick(4);
    noisysignal = 4'h0;
    tick(4);
    check("lat_fall_e4", 32'(conditioned), 32'h2);
    tick(1);
    check("lat_fall_e5", 32'(conditioned), 32'h0);
    check("lat_neg_e5",  32'(negativeedge), 32'h2);
    tick(1);
    check("lat_neg_e6",  32'(negativeedge), 32'h0);
    tick(3);

    // Bounce on ch2: 1,0,1,1,1,1 then held
    bounce    = 6'b111101;
    pos_count = 0;
    for (int k = 1; k <= 12; k++) begin
      noisysignal[2] = (k <= 6) ? bounce[k-1] : 1'b1;
      tick(1);
      if (positiveedge[2]) pos_count++;
      if (k == 6) check("bounce_cond_e6", 32'(conditioned[2]), 32'h0);
      if (k == 7) begin
        check("bounce_cond_e7", 32'(conditioned[2]), 32'h1);
        check("bounce_pos_e7",  32'(positiveedge[2]), 32'h1);
      end
    end
    check("bounce_pulses", 32'(pos_count), 32'd1);

    // Independence: ch0 rises while ch3 falls
    noisysignal = 4'b1100;
    tick(8);
    check("ind_pre", 32'(conditioned), 32'hC);
    noisysignal = 4'b0101;
    tick(4);
    check("ind_e4", 32'(conditioned), 32'hC);
    tick(1);
    check("ind_pos", 32'(positiveedge), 32'b0001);
    check("ind_neg", 32'(negativeedge), 32'b1000);
    check("ind_cond", 32'(conditioned), 32'b0101);
`ifndef MULTI_INPUT_CONDITIONER_STICKY_EN
    check("noflag", 32'(edgeflag), 32'h0);
`endif
    tick(3);

    // Asynchronous reset between clock edges, then mid-debounce discard
    #4;
    reset = 1'b1;
    #1;
    check("async_cond", 32'(conditioned), 32'h0);
    tick(1);
    reset = 1'b0;
    noisysignal = 4'h8;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4);
    check("discard_e4", 32'(conditioned), 32'h0);
    tick(1);
    check("discard_e5", 32'(conditioned), 32'h8);
    check("discard_pos", 32'(positiveedge), 32'h8);
    tick(2);

`ifdef MULTI_INPUT_CONDITIONER_STICKY_EN
    // Sticky flag on ch2
    check("flag_pre", 32'(edgeflag), 32'h8);
    clearflags = 4'h8;
    tick(1);
    clearflags = 4'h0;
    check("flag_clr8", 32'(edgeflag), 32'h0);
    noisysignal = 4'hC;
    tick(15);
    check("flag_hold", 32'(edgeflag), 32'h4);
    clearflags = 4'h4;
    tick(1);
    clearflags = 4'h0;
    check("flag_clr", 32'(edgeflag), 32'h0);
    noisysignal = 4'h8;
    tick(5);
    check("flag_edge", 32'(negativeedge), 32'h4);
    clearflags = 4'h4;
    tick(1);
    clearflags = 4'h0;
    check("flag_setwins", 32'(edgeflag), 32'h4);
`endif

    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end
endmodule
`default_nettype wire
